temp_sense_monitor: RTL and testbench

Measures one on-die ring-oscillator temperature sensor by counting its edges over a fixed window of system-clock cycles. Sits directly upstream of the control block, which instantiates four copies:
- `temp_counter` drives `temp_counter_N`.
- `temp_sense_good` drives `temp_sense_N_good`.
- Control supplies `temp_threshold_N` back to this block.

Good/bad status is debounced over consecutive windows so a single noisy sample cannot toggle the health flag.

---
 rtl/temp_sense_monitor.sv | 170 +++++++++++++++++
 tb/tb_temp_sense_monitor.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/temp_sense_monitor.sv
// temp_sense_monitor
//
// Measures one ring-oscillator temperature sensor. The block counts the
// sensor's rising edges over a fixed window of system-clock cycles and
// reports the count. It also keeps a debounced good/bad health flag, which
// changes only after DEBOUNCE consecutive windows disagree with it.
//
// Parameters:
//   WINDOW_CYCLES  clk cycles per measurement window (2..65535)
//   DEBOUNCE       consecutive disagreeing windows needed to flip the flag (1..15)
//
// Ports:
//   clk              system clock
//   rst_n            asynchronous active-low reset
//   ro_in            raw ring-oscillator output (asynchronous to clk)
//   enable           measurement enable, synchronous to clk
//   temp_threshold   bad limit; a window is bad when count >= threshold
//   temp_counter     edge count of the last completed window
//   temp_sense_good  debounced health flag
//   sample_valid     one-cycle pulse when temp_counter has just updated

module temp_sense_monitor #(
  parameter int WINDOW_CYCLES = 1024,
  parameter int DEBOUNCE      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ro_in,
  input  logic        enable,
  input  logic [13:0] temp_threshold,
  output logic [13:0] temp_counter,
  output logic        temp_sense_good,
  output logic        sample_valid
);

  localparam int              WW       = $clog2(WINDOW_CYCLES + 1);
  localparam logic [WW-1:0]   WIN_LAST = WW'(WINDOW_CYCLES - 1);
  localparam logic [3:0]      DEB_LIM  = 4'(DEBOUNCE);
  localparam logic [13:0]     CNT_MAX  = 14'h3FFF;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    COUNT,
    LATCH
  } state_t;

  state_t        state_q;
  logic          settle_q;
  logic [WW-1:0] win_cnt_q;
  logic [13:0]   edge_cnt_q;
  logic [13:0]   edge_cnt_d;
  logic [3:0]    deb_q;
  logic [3:0]    deb_d;
  logic          good_q;
  logic          good_d;
  logic [13:0]   count_q;
  logic          valid_q;

  logic          sync1_q;
  logic          sync2_q;
  logic          prev_q;
  logic          ro_rise;
  logic          window_good;

  // Two-flop synchroniser followed by an edge register. A rising edge is
  // seen when the synchronised level is high and was low the cycle before.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= ro_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign ro_rise = sync2_q & ~prev_q;

  // Saturating increment: the count sticks at 14'h3FFF rather than wrapping.
  assign edge_cnt_d  = (edge_cnt_q == CNT_MAX) ? edge_cnt_q : edge_cnt_q + 14'd1;

  assign window_good = (edge_cnt_q < temp_threshold);

  // Debounce: a verdict that agrees with the current flag clears the run of
  // disagreements; DEBOUNCE disagreements in a row flip the flag.
  always_comb begin
    deb_d  = deb_q;
    good_d = good_q;
    if (window_good == good_q) begin
      deb_d = 4'd0;
    end else if (deb_q + 4'd1 == DEB_LIM) begin
      deb_d  = 4'd0;
      good_d = ~good_q;
    end else begin
      deb_d = deb_q + 4'd1;
    end
  end

  // Measurement FSM. Dropping enable in SETTLE or COUNT abandons the partial
  // window without touching the reported outputs or the debounce state.
  // Back-to-back windows go LATCH -> COUNT directly, since the synchroniser
  // is already primed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      settle_q   <= 1'b0;
      win_cnt_q  <= '0;
      edge_cnt_q <= 14'd0;
      deb_q      <= 4'd0;
      good_q     <= 1'b0;
      count_q    <= 14'd0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q  <= SETTLE;
            settle_q <= 1'b0;
          end
        end
        SETTLE: begin
          win_cnt_q  <= '0;
          edge_cnt_q <= 14'd0;
          if (!enable) begin
            state_q <= IDLE;
          end else if (settle_q) begin
            state_q <= COUNT;
          end else begin
            settle_q <= 1'b1;
          end
        end
        COUNT: begin
          if (!enable) begin
            state_q <= IDLE;
          end else begin
            if (ro_rise) begin
              edge_cnt_q <= edge_cnt_d;
            end
            if (win_cnt_q == WIN_LAST) begin
              state_q <= LATCH;
            end else begin
              win_cnt_q <= win_cnt_q + WW'(1);
            end
          end
        end
        LATCH: begin
          count_q    <= edge_cnt_q;
          valid_q    <= 1'b1;
          deb_q      <= deb_d;
          good_q     <= good_d;
          edge_cnt_q <= 14'd0;
          win_cnt_q  <= '0;
          state_q    <= enable ? COUNT : IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign temp_counter    = count_q;
  assign temp_sense_good = good_q;
  assign sample_valid    = valid_q;

endmodule

// File: tb/tb_temp_sense_monitor.sv
// tb_temp_sense_monitor
//
// Scoreboard bench for temp_sense_monitor. The stimulus side drives ro_in,
// enable and temp_threshold on falling edges, records them per cycle, and
// when a window completes computes the expected sample from the recorded
// history. A separate monitor pops expectations whenever sample_valid
// is seen, and otherwise checks that the outputs hold.
//
// A second instance with a very long window and a toggling input checks
// saturation of the edge count.

module tb_temp_sense_monitor;

  localparam int W     = 64;
  localparam int DEB   = 2;
  localparam int SAT_W = 33000;
  localparam int MAXC  = 65536;

  typedef struct {
    int          cycle;
    logic [13:0] count;
    logic        good;
  } sample_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ro_in;
  logic        enable;
  logic [13:0] thr;
  logic [13:0] temp_counter;
  logic        temp_sense_good;
  logic        sample_valid;

  logic        satRstN;
  logic        satRo;
  logic        satEnable;
  logic [13:0] satCounter;
  logic        satGood;
  logic        satValid;

  int          cyc = 0;
  int          curCyc;
  int          nCompared = 0;
  int          nMismatch = 0;

  bit          vHist [MAXC];
  logic [13:0] thrHist [MAXC];
  sample_t     expQ[$];
  sample_t     satQ[$];
  sample_t     monE;
  sample_t     satE;

  logic [13:0] lastCount = 14'd0;
  logic        lastGood  = 1'b0;
  logic        modelGood = 1'b0;
  int          modelRun  = 0;

  logic [13:0] curThr = 14'd100;
  bit          thrJitter = 1'b0;
  bit          roLevel = 1'b0;
  int          roHold = 0;
  int          roFixedHalf = 2;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  temp_sense_monitor #(.WINDOW_CYCLES(W), .DEBOUNCE(DEB)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ro_in           (ro_in),
    .enable          (enable),
    .temp_threshold  (thr),
    .temp_counter    (temp_counter),
    .temp_sense_good (temp_sense_good),
    .sample_valid    (sample_valid)
  );

  temp_sense_monitor #(.WINDOW_CYCLES(SAT_W), .DEBOUNCE(1)) dutSat (
    .clk             (clk),
    .rst_n           (satRstN),
    .ro_in           (satRo),
    .enable          (satEnable),
    .temp_threshold  (14'h3FFF),
    .temp_counter    (satCounter),
    .temp_sense_good (satGood),
    .sample_valid    (satValid)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic logic [13:0] pickThr();
    case ($urandom_range(0, 5))
      0:       return 14'd0;
      1:       return 14'h3FFF;
      default: return 14'($urandom_range(5, 30));
    endcase
  endfunction

  // Next ro_in level: fixed half period, or a random hold of 1..6 cycles.
  function automatic bit nextRo();
    if (roHold == 0) begin
      roLevel = ~roLevel;
      roHold  = (roFixedHalf != 0) ? roFixedHalf : int'($urandom_range(1, 6));
    end
    roHold--;
    return roLevel;
  endfunction

  task automatic driveCycle(input bit en);
    bit r;
    @(negedge clk);
    curCyc = cyc;
    if (thrJitter && $urandom_range(0, 39) == 0) curThr = pickThr();
    r      = nextRo();
    ro_in  = r;
    enable = en;
    thr    = curThr;
    if (curCyc < MAXC) begin
      vHist[curCyc]   = r;
      thrHist[curCyc] = curThr;
    end
  endtask

  // Window whose first counting cycle is s: an edge that appears on ro_in in
  // cycle a is counted in cycle a+2, so count rises with v[c-2]=1, v[c-3]=0.
  task automatic finishWindow(input int s);
    int      n;
    bit      verdictGood;
    sample_t e;
    n = 0;
    for (int c = s; c < s + W; c++)
      if (vHist[c-2] && !vHist[c-3]) n++;
    if (n > 16383) n = 16383;
    verdictGood = (n < int'(thrHist[s+W]));
    if (verdictGood == modelGood) begin
      modelRun = 0;
    end else begin
      modelRun++;
      if (modelRun == DEB) begin
        modelGood = verdictGood;
        modelRun  = 0;
      end
    end
    e.cycle = s + W + 1;
    e.count = 14'(n);
    e.good  = modelGood;
    expQ.push_back(e);
  endtask

  task automatic doReset();
    #2;
    rst_n = 1'b0;
    expQ.delete();
    modelGood = 1'b0;
    modelRun  = 0;
    lastCount = 14'd0;
    lastGood  = 1'b0;
    #1;
    checkOutput("reset_now_counter", temp_counter, 0);
    checkOutput("reset_now_good", temp_sense_good, 0);
    checkOutput("reset_now_valid", sample_valid, 0);
    repeat (2) driveCycle(1'b0);
    rst_n = 1'b1;
  endtask

  // One enable session: nWin complete windows, then
  //   mode 0: end normally (enable low during the last LATCH)
  //   mode 1: drop enable partway through the following window
  //   mode 2: assert reset partway through the following window
  task automatic applyStimulus(input int nWin, input int mode);
    int e;
    int s;
    int lo;
    int l;
    driveCycle(1'b1);
    e = curCyc;
    for (int j = 0; j < nWin; j++) begin
      s = e + 3 + j * (W + 1);
      while (curCyc < s + W - 1) driveCycle(1'b1);
      driveCycle((j < nWin - 1) || (mode != 0));
      finishWindow(s);
    end
    if (mode != 0) begin
      s  = e + 3 + nWin * (W + 1);
      lo = (nWin == 0) ? e + 1 : s;
      l  = int'($urandom_range(lo, s + W - 1));
      while (curCyc < l - 1) driveCycle(1'b1);
      driveCycle(1'b0);
      if (mode == 2) doReset();
    end
    repeat ($urandom_range(0, 4)) driveCycle(1'b0);
  endtask

  // Main-instance monitor.
  always @(posedge clk) begin
    #1;
    if (sample_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        nCompared++;
        nMismatch++;
        $display("[TB] FAIL spurious_valid: got sample_valid=1, expected no pulse (cycle %0d)", cyc);
      end else begin
        monE = expQ.pop_front();
        checkOutput("valid_cycle", cyc, monE.cycle);
        checkOutput("temp_counter", temp_counter, monE.count);
        checkOutput("temp_sense_good", temp_sense_good, monE.good);
        lastCount = monE.count;
        lastGood  = monE.good;
      end
    end else begin
      checkOutput("hold_counter", temp_counter, lastCount);
      checkOutput("hold_good", temp_sense_good, lastGood);
    end
  end

  // Saturation-instance monitor.
  always @(posedge clk) begin
    #1;
    if (satValid === 1'b1) begin
      if (satQ.size() == 0) begin
        nCompared++;
        nMismatch++;
        $display("[TB] FAIL sat_spurious_valid: got sample_valid=1, expected no pulse (cycle %0d)", cyc);
      end else begin
        satE = satQ.pop_front();
        checkOutput("sat_valid_cycle", cyc, satE.cycle);
        checkOutput("sat_counter", satCounter, satE.count);
        checkOutput("sat_good", satGood, satE.good);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    satRo = ~satRo;
  end

  // Saturation instance: input toggles every cycle (period 2 clk), giving
  // 16500 edges per window, beyond the 14-bit range.
  initial begin
    sample_t s;
    satRstN   = 1'b1;
    satEnable = 1'b0;
    satRo     = 1'b0;
    #1 satRstN = 1'b0;
    repeat (3) @(negedge clk);
    satRstN = 1'b1;
    @(negedge clk);
    satEnable = 1'b1;
    s.cycle = cyc + 3 + SAT_W + 1;
    s.count = 14'h3FFF;
    s.good  = 1'b0;
    satQ.push_back(s);
  end

  initial begin
    int nWin;
    int mode;
    int waited;
    rst_n  = 1'b1;
    enable = 1'b0;
    ro_in  = 1'b0;
    thr    = 14'd100;
    #1 rst_n = 1'b0;
    enable = 1'b1;

    // Reset held with enable high and ro toggling.
    repeat (10) begin
      @(negedge clk);
      ro_in  = ~ro_in;
      enable = 1'b1;
      #1;
      checkOutput("reset_counter", temp_counter, 0);
      checkOutput("reset_good", temp_sense_good, 0);
      checkOutput("reset_valid", sample_valid, 0);
    end
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) driveCycle(1'b0);

    // Nominal: period 4 cycles, threshold 100; good rises on 2nd window.
    roFixedHalf = 2;
    curThr = 14'd100;
    applyStimulus(3, 0);
    // Over-temperature, then recovery.
    curThr = 14'd10;
    applyStimulus(3, 0);
    curThr = 14'd100;
    applyStimulus(3, 0);
    // Threshold equal to the count is bad; one above is good.
    curThr = 14'd16;
    applyStimulus(2, 0);
    curThr = 14'd17;
    applyStimulus(2, 0);
    // Enable aborts, then a clean window afterwards.
    applyStimulus(1, 1);
    applyStimulus(0, 1);
    applyStimulus(1, 0);
    // Reset after one bad window while good=1, then two good windows.
    curThr = 14'd10;
    applyStimulus(1, 2);
    curThr = 14'd100;
    applyStimulus(2, 0);

    // Randomised sessions.
    roFixedHalf = 0;
    thrJitter   = 1'b1;
    for (int i = 0; i < 24; i++) begin
      curThr = pickThr();
      nWin   = int'($urandom_range(0, 3));
      mode   = (nWin == 0) ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 2));
      applyStimulus(nWin, mode);
    end
    thrJitter = 1'b0;
    repeat (4) driveCycle(1'b0);
    checkOutput("pending_main", expQ.size(), 0);

    waited = 0;
    while (satQ.size() != 0 && waited < SAT_W + 2000) begin
      @(posedge clk);
      waited++;
    end
    repeat (2) @(posedge clk);
    checkOutput("sat_pending", satQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
